fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch control stage sitting directly upstream of the program-counter register. Reads the current PC, issues instruction-memory requests with a req/ack handshake, and drives the PC register's next-value and enable inputs. Also owns the IF/ID pipeline register with stall, flush and redirect handling. The PC register has no reset of its own, so this block loads the reset vector into it.

## Interface
- RESET_VECTOR, 32'h0000_0000: address loaded into the PC after reset; bits [1:0] must be 0.
- NOP_INSTR, 32'h0000_0000: instruction word placed in IF/ID on reset and flush.

- clk  input  1  rising-edge clock; the block's only clock.
- rst  input  1  synchronous, active-high reset.
- pc_cur  input  32  current PC, from the PC register output.
- pc_next  output  32  next-PC value, to the PC register input.
- pc_en  output  1  PC load enable, to the PC register enable.
- imem_req  output  1  instruction-memory request.
- imem_addr  output  32  request address; always equals pc_cur.
- imem_ack  input  1  one-cycle acknowledge; imem_rdata is valid in the same cycle.
- imem_rdata  input  32  fetched instruction word.
- stall  input  1  hazard-unit freeze of PC and IF/ID.
- redirect  input  1  branch/jump taken this cycle.
- redirect_target  input  32  new PC; bits [1:0] are forced to 0.
- ifid_valid  output  1  IF/ID holds a real instruction.
- ifid_instr  output  32  IF/ID instruction.
- ifid_pc  output  32  IF/ID instruction address.
- ifid_pc4  output  32  ifid_pc + 4.

## Operation
- FSM states: BOOT, FETCH, HOLD, DRAIN. Reset enters BOOT.
- pc_en, pc_next, imem_req and imem_addr are combinational from state and inputs. All IF/ID outputs are registered.
- Reset values:
  - ifid_valid = 0, ifid_instr = NOP_INSTR, ifid_pc = 0, ifid_pc4 = 0.
  - Pending-target register = 0; skid buffer = 0.
- BOOT:
  - pc_en = 1, pc_next = RESET_VECTOR, imem_req = 0.
  - Goes to FETCH on the first edge with rst = 0.
  - The PC therefore holds RESET_VECTOR from the first clock edge with rst high.
- FETCH:
  - imem_req = 1, imem_addr = pc_cur.
  - Req and addr stay stable until ack; the PC never changes while a request is unacknowledged.
  - ack, no redirect, no stall:
    - IF/ID loads valid = 1, instr = rdata, pc = pc_cur, pc4 = pc_cur + 4.
    - pc_en = 1, pc_next = pc_cur + 4. Stay in FETCH.
  - ack with stall (no redirect):
    - rdata is captured into the skid buffer; pc_en = 0; IF/ID holds.
    - Go to HOLD.
  - ack with redirect:
    - Data is discarded; pc_en = 1, pc_next = target.
    - Flush IF/ID (valid = 0, instr = NOP_INSTR). Stay in FETCH.
  - No ack, redirect:
    - Latch target into the pending register; flush IF/ID; pc_en = 0.
    - Go to DRAIN.
  - No ack, no redirect:
    - pc_en = 0.
    - If stall = 0, ifid_valid <= 0 (bubble; other IF/ID fields hold).
    - If stall = 1, IF/ID holds entirely.
- HOLD:
  - imem_req = 0; skid buffer and IF/ID hold.
  - stall drops, no redirect:
    - IF/ID loads the skid word, pc_cur and pc_cur + 4.
    - pc_en = 1, pc_next = pc_cur + 4. Go to FETCH.
  - redirect (stall ignored): discard the skid word, pc_en = 1, pc_next = target, flush IF/ID. Go to FETCH.
- DRAIN:
  - imem_req = 1 at the old address.
  - A redirect here overwrites the pending target (newest wins).
  - On ack:
    - Data is discarded.
    - pc_en = 1, pc_next = pending target, or redirect_target if redirect is asserted in the same cycle.
    - Go to FETCH.
  - IF/ID stays flushed throughout DRAIN.
- Priority: rst > redirect > stall > normal advance.
- Arithmetic: all PC adds are 32-bit modulo 2^32, so 32'hFFFF_FFFC + 4 = 32'h0000_0000.

## Timing
- Zero-wait memory (ack in the same cycle as req): one instruction per cycle, and ifid_valid is continuous.
- N-wait memory: one instruction per N+1 cycles, with N bubble cycles (ifid_valid = 0) between instructions.
- Redirect penalty:
  - The flush appears at the next edge.
  - The first target instruction reaches IF/ID at the earliest 2 edges after redirect (zero-wait memory).
  - In DRAIN, the penalty extends by the remaining wait cycles.
- Stall: IF/ID and PC are frozen on the same edge stall is sampled high. Release resumes on the edge after stall falls.
- rst asserted mid-transaction:
  - The FSM goes to BOOT and the in-flight ack is ignored.
  - imem_req drops in the same cycle, because it is combinational on state and rst.

## Test plan
- Reset, then zero-wait memory returning rdata = addr ^ 32'hA5A5_A5A5 -> PC sequence 0, 4, 8, …; ifid_instr matches each word; ifid_valid stays 1.
- Memory with 2 wait cycles -> ifid_valid pattern 0, 0, 1 repeating; imem_addr stays stable until each ack; PC advances only on ack.
- stall asserted for 3 cycles at the same edge as an ack -> FSM in HOLD; PC and IF/ID frozen; after release, the skid word appears in IF/ID with the correct ifid_pc.
- redirect to 32'h0000_1003 while in FETCH with no ack, 2 wait cycles -> DRAIN; flushed word discarded; PC becomes 32'h0000_1000; next ifid_pc = 32'h0000_1000.
- redirect and stall asserted together in HOLD -> redirect wins; IF/ID flushed to NOP_INSTR with valid = 0; PC = target.
- PC at 32'hFFFF_FFFC with a fetch acked -> pc_next = 0 and ifid_pc4 = 0. rst pulsed mid-wait -> PC reloads RESET_VECTOR and all IF/ID outputs return to their reset values.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bundle between the fetch stage and imem.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_unit.sv
// Fetch control: drives the external PC register, runs the imem req/ack
// handshake and owns the IF/ID register with stall, flush and redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        pc_cur,
  output logic [31:0]        pc_next,
  output logic               pc_en,
  fetch_unit_if.master       imem,
  input  logic               stall,
  input  logic               redirect,
  input  logic [31:0]        redirect_target,
  output logic               ifid_valid,
  output logic [31:0]        ifid_instr,
  output logic [31:0]        ifid_pc,
  output logic [31:0]        ifid_pc4
);

  localparam logic [1:0] BOOT  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic [31:0] pend_q, pend_d;
  logic [31:0] skid_q, skid_d;

  logic [31:0] pc_plus4;
  logic [31:0] target;

  assign pc_plus4       = pc_cur + 32'd4;
  assign target         = redirect_target & ~32'h0000_0003;
  assign imem.imem_addr = pc_cur;

  assign ifid_valid = ifid_valid_q;
  assign ifid_instr = ifid_instr_q;
  assign ifid_pc    = ifid_pc_q;
  assign ifid_pc4   = ifid_pc4_q;

  always_comb begin
    state_d       = state_q;
    ifid_valid_d  = ifid_valid_q;
    ifid_instr_d  = ifid_instr_q;
    ifid_pc_d     = ifid_pc_q;
    ifid_pc4_d    = ifid_pc4_q;
    pend_d        = pend_q;
    skid_d        = skid_q;
    pc_en         = 1'b0;
    pc_next       = pc_plus4;
    imem.imem_req = 1'b0;

    // The PC register has no reset, so reset itself must load the vector.
    if (rst) begin
      pc_en   = 1'b1;
      pc_next = RESET_VECTOR;
    end else begin
      case (state_q)
        BOOT: begin
          pc_en   = 1'b1;
          pc_next = RESET_VECTOR;
          state_d = FETCH;
        end
        FETCH: begin
          imem.imem_req = 1'b1;
          if (imem.imem_ack) begin
            if (redirect) begin
              pc_en        = 1'b1;
              pc_next      = target;
              ifid_valid_d = 1'b0;
              ifid_instr_d = NOP_INSTR;
            end else if (stall) begin
              skid_d  = imem.imem_rdata;
              state_d = HOLD;
            end else begin
              pc_en        = 1'b1;
              ifid_valid_d = 1'b1;
              ifid_instr_d = imem.imem_rdata;
              ifid_pc_d    = pc_cur;
              ifid_pc4_d   = pc_plus4;
            end
          end else if (redirect) begin
            pend_d       = target;
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_INSTR;
            state_d      = DRAIN;
          end else if (!stall) begin
            ifid_valid_d = 1'b0;
          end
        end
        HOLD: begin
          if (redirect) begin
            pc_en        = 1'b1;
            pc_next      = target;
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_INSTR;
            state_d      = FETCH;
          end else if (!stall) begin
            pc_en        = 1'b1;
            ifid_valid_d = 1'b1;
            ifid_instr_d = skid_q;
            ifid_pc_d    = pc_cur;
            ifid_pc4_d   = pc_plus4;
            state_d      = FETCH;
          end
        end
        DRAIN: begin
          // The old request must complete before the target can be issued.
          imem.imem_req = 1'b1;
          if (imem.imem_ack) begin
            pc_en   = 1'b1;
            pc_next = redirect ? target : pend_q;
            state_d = FETCH;
          end else if (redirect) begin
            pend_d = target;
          end
        end
        default: state_d = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= BOOT;
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= NOP_INSTR;
      ifid_pc_q    <= '0;
      ifid_pc4_q   <= '0;
      pend_q       <= '0;
      skid_q       <= '0;
    end else begin
      state_q      <= state_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      pend_q       <= pend_d;
      skid_q       <= skid_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: models the PC register and a wait-state imem,
// runs table-driven fetch streams and hand-written corner sequences.
module tb_fetch_unit;

  localparam logic [31:0] RV   = 32'h0000_0000;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] XMSK = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_cur;
  logic [31:0] pc_next;
  logic        pc_en;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc4;

  int unsigned waits = 0;
  int unsigned wcnt  = 0;
  int unsigned total = 0;
  int unsigned bad   = 0;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_VECTOR(RV), .NOP_INSTR(NOP)) dut (
    .clk             (clk),
    .rst             (rst),
    .pc_cur          (pc_cur),
    .pc_next         (pc_next),
    .pc_en           (pc_en),
    .imem            (bus),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .ifid_valid      (ifid_valid),
    .ifid_instr      (ifid_instr),
    .ifid_pc         (ifid_pc),
    .ifid_pc4        (ifid_pc4)
  );

  always #5 clk = ~clk;

  // PC register without reset, loaded only through pc_en.
  always @(posedge clk) if (pc_en) pc_cur <= pc_next;

  // Memory acks after `waits` idle request cycles; data derived from address.
  assign bus.imem_ack   = bus.imem_req && (wcnt == waits);
  assign bus.imem_rdata = bus.imem_addr ^ XMSK;
  always @(posedge clk) begin
    if (bus.imem_req && !bus.imem_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    logic p_req, p_ack, p_rst;
    logic [31:0] p_pc;
    #2;
    p_req = bus.imem_req; p_ack = bus.imem_ack; p_rst = rst; p_pc = pc_cur;
    @(posedge clk);
    #1;
    if (p_req && !p_ack && !p_rst) chk("pc_frozen_while_pending", pc_cur, p_pc);
  endtask

  task automatic do_reset(input int unsigned w);
    waits = w; stall = 0; redirect = 0; redirect_target = '0;
    rst = 1; tick(); tick();
    rst = 0; tick();
  endtask

  typedef struct {
    int unsigned waits;
    int unsigned n;
    int unsigned cycles;
  } vec_t;

  vec_t        vecs[4];
  logic [31:0] exp_q[$];

  initial begin
    vecs[0] = '{waits: 0, n: 6, cycles: 6};
    vecs[1] = '{waits: 2, n: 4, cycles: 12};
    vecs[2] = '{waits: 1, n: 5, cycles: 10};
    vecs[3] = '{waits: 3, n: 3, cycles: 12};

    // Reset state
    rst = 1; tick(); tick();
    chk("rst_valid", {31'd0, ifid_valid}, 32'd0);
    chk("rst_instr", ifid_instr, NOP);
    chk("rst_pc", ifid_pc, 32'd0);
    chk("rst_pc4", ifid_pc4, 32'd0);
    chk("rst_pc_cur", pc_cur, RV);
    chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
    rst = 0; #1;
    chk("boot_req", {31'd0, bus.imem_req}, 32'd0);
    chk("boot_pc_en", {31'd0, pc_en}, 32'd1);
    tick();
    chk("fetch_req", {31'd0, bus.imem_req}, 32'd1);
    chk("fetch_addr", bus.imem_addr, RV);

    // Streams with varying wait states, checked against a scoreboard
    for (int unsigned v = 0; v < 4; v++) begin
      int unsigned cyc, got, gap;
      logic [31:0] e;
      do_reset(vecs[v].waits);
      exp_q.delete();
      for (int unsigned k = 0; k < vecs[v].n; k++) exp_q.push_back(RV + 32'(4 * k));
      cyc = 0; got = 0; gap = 0;
      while (got < vecs[v].n && cyc < 200) begin
        tick(); cyc++;
        if (ifid_valid) begin
          if (exp_q.size() == 0) begin
            chk("stream_extra", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("stream_pc", ifid_pc, e);
            chk("stream_instr", ifid_instr, e ^ XMSK);
            chk("stream_pc4", ifid_pc4, e + 32'd4);
          end
          chk("stream_gap", gap, vecs[v].waits);
          gap = 0; got++;
        end else begin
          gap++;
        end
      end
      chk("stream_cycles", cyc, vecs[v].cycles);
      chk("stream_left", exp_q.size(), 0);
    end

    // Stall on an ack: HOLD for 3 cycles, then the skid word lands
    do_reset(0);
    tick(); tick(); tick();
    stall = 1; tick();
    chk("hold_req", {31'd0, bus.imem_req}, 32'd0);
    chk("hold_pc_cur", pc_cur, 32'd12);
    chk("hold_ifid_pc", ifid_pc, 32'd8);
    tick(); tick();
    chk("hold3_pc_cur", pc_cur, 32'd12);
    chk("hold3_ifid_pc", ifid_pc, 32'd8);
    chk("hold3_instr", ifid_instr, 32'd8 ^ XMSK);
    stall = 0; tick();
    chk("skid_pc", ifid_pc, 32'd12);
    chk("skid_instr", ifid_instr, 32'd12 ^ XMSK);
    chk("skid_valid", {31'd0, ifid_valid}, 32'd1);
    chk("skid_pc_cur", pc_cur, 32'd16);

    // Redirect while waiting: DRAIN, then the aligned target
    do_reset(2);
    tick(); tick(); tick();
    redirect = 1; redirect_target = 32'h0000_1003; tick();
    redirect = 0;
    chk("drain_valid", {31'd0, ifid_valid}, 32'd0);
    chk("drain_instr", ifid_instr, NOP);
    chk("drain_addr", bus.imem_addr, 32'd4);
    tick(); tick();
    chk("drain_pc_cur", pc_cur, 32'h0000_1000);
    chk("drain_still_flushed", {31'd0, ifid_valid}, 32'd0);
    tick(); tick();
    chk("drain_bubble", {31'd0, ifid_valid}, 32'd0);
    tick();
    chk("tgt_ifid_pc", ifid_pc, 32'h0000_1000);
    chk("tgt_instr", ifid_instr, 32'h0000_1000 ^ XMSK);

    // Newer redirect in DRAIN replaces the pending target
    do_reset(2);
    redirect = 1; redirect_target = 32'h0000_0500; tick();
    redirect_target = 32'h0000_0600; tick();
    redirect = 0; tick();
    chk("drain_newest", pc_cur, 32'h0000_0600);

    // Redirect and stall together in HOLD
    do_reset(0);
    tick(); tick();
    stall = 1; tick();
    redirect = 1; redirect_target = 32'h0000_0300; tick();
    redirect = 0;
    chk("hr_valid", {31'd0, ifid_valid}, 32'd0);
    chk("hr_instr", ifid_instr, NOP);
    chk("hr_pc_cur", pc_cur, 32'h0000_0300);
    stall = 0; tick();
    chk("hr_next_pc", ifid_pc, 32'h0000_0300);

    // Wrap at the top of the address space
    do_reset(0);
    tick();
    redirect = 1; redirect_target = 32'hFFFF_FFFC; tick();
    redirect = 0; #1;
    chk("wrap_pc_cur", pc_cur, 32'hFFFF_FFFC);
    chk("wrap_pc_next", pc_next, 32'h0000_0000);
    tick();
    chk("wrap_ifid_pc", ifid_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", ifid_pc4, 32'h0000_0000);

    // Reset mid-wait
    do_reset(2);
    for (int i = 0; i < 7; i++) tick();
    chk("pre_rst_valid", {31'd0, ifid_valid}, 32'd0);
    chk("pre_rst_ifid_pc", ifid_pc, 32'd4);
    rst = 1; #1;
    chk("rst_req_drop", {31'd0, bus.imem_req}, 32'd0);
    chk("rst_pc_next", pc_next, RV);
    tick();
    chk("mrst_pc_cur", pc_cur, RV);
    chk("mrst_instr", ifid_instr, NOP);
    chk("mrst_pc", ifid_pc, 32'd0);
    chk("mrst_pc4", ifid_pc4, 32'd0);
    rst = 0; tick();
    chk("mrst_fetch_addr", bus.imem_addr, RV);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
